// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480 timing constants and decoder state encoding shared by sync and sync_decoder.
package vga_timing_pkg;
  localparam logic [9:0] H_DATW = 10'd640;
  localparam logic [9:0] H_FRNP = 10'd16;
  localparam logic [9:0] H_PULW = 10'd96;
  localparam logic [9:0] H_BCKP = 10'd48;
  localparam logic [9:0] H_TOTAL = H_DATW + H_FRNP + H_PULW + H_BCKP;
  localparam logic [9:0] H_SYNC_START = H_DATW + H_FRNP;
  localparam logic [9:0] V_DATW = 10'd480;
  localparam logic [9:0] V_FRNP = 10'd10;
  localparam logic [9:0] V_PULW = 10'd2;
  localparam logic [9:0] V_BCKP = 10'd33;
  localparam logic [9:0] V_TOTAL = V_DATW + V_FRNP + V_PULW + V_BCKP;
  // Row the generator is on when its vsync falls.
  localparam logic [9:0] V_SYNC_ROW = 10'd513;
  localparam logic [10:0] V_PULSE_CYC = {1'b0, V_PULW} * {1'b0, H_TOTAL};
  typedef enum logic [1:0] {ST_SEARCH, ST_HCOUNT, ST_VWAIT, ST_LOCKED} dec_state_e;
  function automatic logic in_tol(input logic [11:0] val, input logic [11:0] nom, input logic [11:0] tol);
    return (val + tol >= nom) && (val <= nom + tol);
  endfunction
endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: sample + delay registers on one sync line, with registered fall/rise flags.
module sync_edge_detect (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_sync,
  output logic o_fall,
  output logic o_rise
);
  logic r_samp;
  logic r_dly;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_samp <= 1'b1;
      r_dly <= 1'b1;
      o_fall <= 1'b0;
      o_rise <= 1'b0;
    end else begin
      r_samp <= i_sync;
      r_dly <= r_samp;
      o_fall <= r_dly & ~r_samp;
      o_rise <= ~r_dly & r_samp;
    end
  end
endmodule

// File: rtl/sync_decoder.sv
// sync_decoder: recovers 640x480 column/row/data-enable and timing lock from incoming hsync/vsync.
// Define SYNC_DECODER_STATS_EN to build the error and locked-frame counters.
module sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int LOCK_LINES = 4,
  parameter int H_TOL      = 0
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_hsync,
  input  logic        i_vsync,
  output logic [9:0]  o_col,
  output logic [9:0]  o_row,
  output logic        o_active,
  output logic        o_locked,
  output logic        o_frame_start,
  output logic [7:0]  o_err_count,
  output logic [15:0] o_frame_count
);
  localparam logic [11:0] TOL = 12'(H_TOL);
  localparam logic [11:0] VTOL = 12'(2 * H_TOL);
  localparam logic [7:0] LOCK = 8'(LOCK_LINES);
  logic w_hfall;
  logic w_hrise;
  logic w_vfall;
  logic w_vrise;
  logic [9:0] r_per;
  logic [9:0] r_hw;
  logic [10:0] r_vw;
  logic [7:0] r_lines;
  dec_state_e r_state;
  dec_state_e w_state_n;
  logic [9:0] w_col_n;
  logic [9:0] w_row_n;
  logic w_good;
  logic w_vgood;
  logic w_sat;
  logic w_drop;
  logic w_lock_n;

  sync_edge_detect u_hs (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_sync  (i_hsync),
    .o_fall  (w_hfall),
    .o_rise  (w_hrise)
  );

  sync_edge_detect u_vs (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_sync  (i_vsync),
    .o_fall  (w_vfall),
    .o_rise  (w_vrise)
  );

  assign w_good = in_tol({2'b0, r_per}, {2'b0, H_TOTAL}, TOL) && in_tol({2'b0, r_hw}, {2'b0, H_PULW}, TOL);
  assign w_vgood = in_tol({1'b0, r_vw}, {1'b0, V_PULSE_CYC}, VTOL);
  assign w_sat = &r_per;
  // A closing hsync edge judges the line just finished; once locked, vsync width and a silent hsync also count.
  assign w_drop = (r_state != ST_SEARCH) &&
                  ((w_hfall && !w_good) || (r_state == ST_LOCKED && ((w_vrise && !w_vgood) || w_sat)));
  assign w_state_n = w_drop ? ST_SEARCH :
                     (r_state == ST_SEARCH && w_hfall) ? ST_HCOUNT :
                     (r_state == ST_HCOUNT && w_hfall && r_lines + 8'd1 >= LOCK) ? ST_VWAIT :
                     (r_state == ST_VWAIT && w_vfall) ? ST_LOCKED : r_state;
  assign w_col_n = w_hfall ? H_SYNC_START : (o_col == H_TOTAL - 10'd1) ? 10'd0 : o_col + 10'd1;
  assign w_row_n = w_vfall ? V_SYNC_ROW :
                   (w_hfall || o_col != H_TOTAL - 10'd1) ? o_row :
                   (o_row == V_TOTAL - 10'd1) ? 10'd0 : o_row + 10'd1;
  assign w_lock_n = w_state_n == ST_LOCKED;

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= ST_SEARCH;
      r_lines <= '0;
      r_per <= '0;
      r_hw <= '0;
      r_vw <= '0;
      o_col <= '0;
      o_row <= '0;
      o_locked <= 1'b0;
      o_active <= 1'b0;
      o_frame_start <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_lines <= (w_state_n == ST_HCOUNT && r_state == ST_HCOUNT) ? r_lines + {7'd0, w_hfall} : '0;
      r_per <= w_hfall ? 10'd1 : r_per + {9'd0, !w_sat};
      r_hw <= w_hrise ? r_per : r_hw;
      r_vw <= w_vfall ? 11'd1 : r_vw + {10'd0, !(&r_vw)};
      o_col <= w_col_n;
      o_row <= w_row_n;
      o_locked <= w_lock_n;
      o_active <= w_lock_n && w_col_n < H_DATW && w_row_n < V_DATW;
      o_frame_start <= w_lock_n && w_col_n == 10'd0 && w_row_n == 10'd0;
    end
  end

`ifdef SYNC_DECODER_STATS_EN
  logic [7:0] r_err;
  logic [15:0] r_frames;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_err <= '0;
      r_frames <= '0;
    end else begin
      r_err <= r_err + {7'd0, w_drop && r_err != 8'hFF};
      r_frames <= r_frames + {15'd0, o_frame_start};
    end
  end
  assign o_err_count = r_err;
  assign o_frame_count = r_frames;
`else
  assign o_err_count = '0;
  assign o_frame_count = '0;
`endif
endmodule

// File: tb/tb_sync_decoder.sv
// tb_sync_decoder: directed lock/loss/relock scenarios on two decoders (H_TOL=0 and H_TOL=1) fed by one sync model.
`timescale 1ns/1ps
module tb_sync_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic hs = 1'b1;
  logic vs = 1'b1;
  logic [9:0] col0, row0, col1, row1;
  logic act0, act1, lck0, lck1, fs0, fs1;
  logic [7:0] err0, err1;
  logic [15:0] fc0, fc1;
  int checks = 0;
  int errors = 0;
  int gc = 0, gr = 0, hlen = 800, pw = 96, vl = 2;
  logic hold = 1'b0;
  int fs_cnt = 0, fs_col = -1, fs_row = -1, act_cnt = 0;
`ifdef SYNC_DECODER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  always #5 clk = ~clk;

  sync_decoder #(.LOCK_LINES(4), .H_TOL(0)) u0 (
    .i_clock(clk), .i_reset(rst), .i_hsync(hs), .i_vsync(vs),
    .o_col(col0), .o_row(row0), .o_active(act0), .o_locked(lck0),
    .o_frame_start(fs0), .o_err_count(err0), .o_frame_count(fc0)
  );

  sync_decoder #(.LOCK_LINES(4), .H_TOL(1)) u1 (
    .i_clock(clk), .i_reset(rst), .i_hsync(hs), .i_vsync(vs),
    .o_col(col1), .o_row(row1), .o_active(act1), .o_locked(lck1),
    .o_frame_start(fs1), .o_err_count(err1), .o_frame_count(fc1)
  );

  function automatic int st(input int v);
    return STATS ? v : 0;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One pixel per clock; the model's sync pulses start at col 656 and at row 513 col 656.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      hs = hold ? 1'b1 : !(gc >= 656 && gc < 656 + pw);
      vs = !((gr == 513 && gc >= 656) || (gr > 513 && gr < 513 + vl) || (gr == 513 + vl && gc < 656));
      @(posedge clk);
      #1;
      if (fs0) begin
        fs_cnt++;
        fs_col = int'(col0);
        fs_row = int'(row0);
      end
      if (act0) act_cnt++;
      if (gc == hlen - 1) begin
        gc = 0;
        hlen = 800;
        gr = (gr == 524) ? 0 : gr + 1;
      end else gc++;
    end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_col", col0, 0);
    check("rst_row", row0, 0);
    check("rst_locked", lck0, 0);
    check("rst_active", act0, 0);
    check("rst_frame_start", fs0, 0);
    check("rst_err", err0, 0);
    check("rst_frames", fc0, 0);
    // Acquire: 4 good lines then the vsync at row 513.
    run(4000);
    gr = 512;
    run(1458);
    check("lock_early", lck0, 0);
    run(1);
    check("lock_at_vsync", lck0, 1);
    check("lock_tol1", lck1, 1);
    check("lock_col", col0, 656);
    check("lock_row", row0, 513);
    // Roll into the next frame and through its first line.
    fs_cnt = 0;
    act_cnt = 0;
    run(9743);
    check("fs_count", fs_cnt, 1);
    check("fs_col", fs_col, 0);
    check("fs_row", fs_row, 0);
    check("active_row0", act_cnt, 640);
    check("col_end_row0", col0, 799);
    check("row_end_row0", row0, 0);
    check("active_blank", act0, 0);
    check("still_locked", lck0, 1);
    check("frames", fc0, st(1));
    check("frames_tol1", fc1, st(1));
    // One 801-cycle line.
    run(798);
    hlen = 801;
    run(801);
    run(656);
    check("pre_stretch", lck0, 1);
    run(3);
    check("stretch_drop", lck0, 0);
    check("stretch_col", col0, 656);
    check("stretch_tol1", lck1, 1);
    check("stretch_err", err0, st(1));
    check("stretch_err_tol1", err1, st(0));
    run(4141);
    gr = 512;
    run(1459);
    check("relock", lck0, 1);
    check("relock_row", row0, 513);
    check("relock_col", col0, 656);
    check("relock_tol1", lck1, 1);
    check("relock_row_tol1", row1, 513);
    // Hsync stuck high until the period counter saturates.
    hold = 1'b1;
    run(1022);
    check("sat_pre", lck0, 1);
    check("sat_pre_tol1", lck1, 1);
    run(1);
    check("sat_drop", lck0, 0);
    check("sat_drop_tol1", lck1, 0);
    check("sat_err", err0, st(2));
    check("sat_err_tol1", err1, st(1));
    run(77);
    hold = 1'b0;
    run(3841);
    gr = 512;
    run(1459);
    check("sat_relock", lck0, 1);
    check("sat_relock_tol1", lck1, 1);
    check("sat_relock_row", row0, 513);
    // Single-cycle reset mid-line while locked.
    run(100);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("mid_rst_col", col0, 0);
    check("mid_rst_row", row0, 0);
    check("mid_rst_locked", lck0, 0);
    check("mid_rst_active", act0, 0);
    check("mid_rst_fs", fs0, 0);
    check("mid_rst_err", err0, 0);
    check("mid_rst_frames", fc0, 0);
    check("mid_rst_tol1", lck1, 0);
    run(4040);
    gr = 512;
    run(1459);
    check("rst_relock", lck0, 1);
    check("rst_relock_tol1", lck1, 1);
    check("rst_relock_row", row0, 513);
    // Current vsync pulse stretched to 3 lines.
    vl = 3;
    run(2397);
    check("v3_pre", lck0, 1);
    run(3);
    check("v3_drop", lck0, 0);
    check("v3_drop_tol1", lck1, 0);
    check("v3_err", err0, st(1));
    check("v3_err_tol1", err1, st(1));
    // 95-cycle hsync pulses: only the H_TOL=1 decoder may lock.
    vl = 2;
    pw = 95;
    run(4941);
    gr = 512;
    run(1459);
    check("pw95_tol0", lck0, 0);
    check("pw95_tol1", lck1, 1);
    check("pw95_row_tol1", row1, 513);
    check("pw95_err", err0, st(5));
    check("pw95_err_tol1", err1, st(1));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
